// File: rtl/reservoir_mac.sv
// Reservoir dot-product MAC: sums Q1.15 w*s terms into a saturated Q2.15 pre-activation x.
// Latency: x/out_valid register on the 2nd edge after the edge accepting in_last.
// Backpressure: in_ready low in DRAIN/OUT; outputs hold while out_valid && !out_ready.
module reservoir_mac #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [15:0]      w,
    input  logic [15:0]      s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      x,
    output logic             sat,
    output logic [CNT_W-1:0] n_terms
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t state_q, state_d;
    logic   drain_q, drain_d;
    logic   accept;

    logic signed [31:0]      prod_q, prod_d;
    logic                    add_q, add_d;
    logic                    first_q, first_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [16:0]             x_q, x_d;
    logic                    sat_q, sat_d;
    logic [CNT_W-1:0]        n_terms_q, n_terms_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [31:0]      w_ext, s_ext;
    logic signed [ACC_W-1:0] prod_ext, acc_sh;
    logic [ACC_W-17:0]       acc_hi;
    logic [16:0]             x_sat;
    logic                    x_clip;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DRAIN: begin
                if (drain_q) state_d = OUT;
                else         drain_d = 1'b1;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == ACC);
    end

    // Floor shift to Q2.15, then clip anything that does not fit in 17 signed bits.
    always_comb begin
        w_ext    = {{16{w[15]}}, w};
        s_ext    = {{16{s[15]}}, s};
        prod_ext = {{(ACC_W-32){prod_q[31]}}, prod_q};
        acc_sh   = acc_q >>> 15;
        acc_hi   = acc_sh[ACC_W-1:16];
        x_clip   = !((acc_hi == '0) || (acc_hi == '1));
        if (!x_clip)               x_sat = acc_sh[16:0];
        else if (acc_sh[ACC_W-1])  x_sat = 17'h10000;
        else                       x_sat = 17'h0FFFF;
    end

    always_comb begin
        prod_d      = prod_q;
        add_d       = accept;
        first_d     = first_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        sat_d       = sat_q;
        n_terms_d   = n_terms_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            prod_d  = w_ext * s_ext;
            first_d = (state_q == IDLE);
            if (state_q == IDLE)  cnt_d = CNT_W'(1);
            else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        // The first product of a sum overwrites the stale accumulator instead of a clear cycle.
        if (add_q) begin
            acc_d = first_q ? prod_ext : acc_q + prod_ext;
        end
        if (state_q == DRAIN && drain_q) begin
            x_d         = x_sat;
            sat_d       = x_clip;
            n_terms_d   = cnt_q;
            out_valid_d = 1'b1;
        end
        if (state_q == OUT && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= '0;
            add_q       <= 1'b0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            sat_q       <= 1'b0;
            n_terms_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            add_q       <= add_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            sat_q       <= sat_d;
            n_terms_q   <= n_terms_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x         = x_q;
    assign sat       = sat_q;
    assign n_terms   = n_terms_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reservoir_mac.sv
// Bench for reservoir_mac: directed corner sums plus random sums checked against an arithmetic model.
module tb_reservoir_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] w;
    logic [15:0] s;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] x;
    logic        sat;
    logic [7:0]  n_terms;

    int errors = 0;
    int checks = 0;

    logic [15:0] qw[$];
    logic [15:0] qs[$];

    reservoir_mac #(.ACC_W(40), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .w         (w),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .sat       (sat),
        .n_terms   (n_terms)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product, floor-divided by 2^15, clipped to 17 signed bits.
    task automatic model(output logic [16:0] ex, output logic es, output logic [7:0] en);
        longint sum = 0;
        longint q;
        foreach (qw[i]) sum += longint'($signed(qw[i])) * longint'($signed(qs[i]));
        q = sum / 32768;
        if ((sum % 32768) != 0 && sum < 0) q = q - 1;
        es = 1'b1;
        if (q > 65535)       ex = 17'h0FFFF;
        else if (q < -65536) ex = 17'h10000;
        else begin
            ex = q[16:0];
            es = 1'b0;
        end
        en = (qw.size() > 255) ? 8'd255 : 8'(qw.size());
    endtask

    task automatic push(input logic [15:0] tw, input logic [15:0] ts, input int n);
        for (int i = 0; i < n; i++) begin
            qw.push_back(tw);
            qs.push_back(ts);
        end
    endtask

    task automatic run_sum(input string tag, input int gap_pct, input int hold, output logic [16:0] xo);
        logic [16:0] ex;
        logic        es;
        logic [7:0]  en;
        int          lat;
        model(ex, es, en);
        for (int i = 0; i < qw.size(); i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
                w        = 16'($urandom);
                s        = 16'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clk);
            if (i == 0) chk({tag, ":in_ready_first"}, 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            w        = qw[i];
            s        = qs[i];
            in_last  = (i == qw.size() - 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, ":in_ready_drain"}, 64'(in_ready), 64'(0));
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ":latency"}, 64'(lat), 64'(2));
        chk({tag, ":x"}, 64'(x), 64'(ex));
        chk({tag, ":sat"}, 64'(sat), 64'(es));
        chk({tag, ":n_terms"}, 64'(n_terms), 64'(en));
        xo = x;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, ":hold_vld"}, 64'(out_valid), 64'(1));
            chk({tag, ":hold_x"}, 64'(x), 64'(ex));
            chk({tag, ":hold_sat"}, 64'(sat), 64'(es));
            chk({tag, ":hold_n"}, 64'(n_terms), 64'(en));
            chk({tag, ":hold_rdy"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ":vld_drop"}, 64'(out_valid), 64'(0));
        chk({tag, ":rdy_back"}, 64'(in_ready), 64'(1));
        qw.delete();
        qs.delete();
    endtask

    initial begin
        logic [16:0] xr;
        logic [16:0] x_nogap;
        logic [15:0] rw[4];
        logic [15:0] rs[4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        w         = '0;
        s         = '0;
        out_ready = 1'b0;
        #1;
        chk("rst:in_ready", 64'(in_ready), 64'(1));
        chk("rst:out_valid", 64'(out_valid), 64'(0));
        chk("rst:x", 64'(x), 64'(0));
        chk("rst:sat", 64'(sat), 64'(0));
        chk("rst:n_terms", 64'(n_terms), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        push(16'h4000, 16'h4000, 2);
        run_sum("basic", 0, 0, xr);
        push(16'h8000, 16'h8000, 3);
        run_sum("pos_clip", 0, 0, xr);
        push(16'h8000, 16'h7FFF, 3);
        run_sum("neg_clip", 0, 0, xr);
        push(16'h1234, 16'hF00D, 3);
        run_sum("backpressure", 0, 5, xr);
        push(16'h7FFF, 16'h0001, 1);
        run_sum("single", 0, 0, xr);

        for (int i = 0; i < 4; i++) begin
            rw[i] = 16'($urandom);
            rs[i] = 16'($urandom);
            qw.push_back(rw[i]);
            qs.push_back(rs[i]);
        end
        run_sum("nogap", 0, 0, x_nogap);
        for (int i = 0; i < 4; i++) begin
            qw.push_back(rw[i]);
            qs.push_back(rs[i]);
        end
        run_sum("gapped", 60, 1, xr);
        chk("gap_equal", 64'(xr), 64'(x_nogap));

        // Abort a sum halfway: two terms in, then reset.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            w        = 16'h7000;
            s        = 16'h7000;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst:in_ready", 64'(in_ready), 64'(1));
        chk("midrst:out_valid", 64'(out_valid), 64'(0));
        chk("midrst:n_terms", 64'(n_terms), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        push(16'h4000, 16'h4000, 1);
        run_sum("after_rst", 0, 0, xr);
        chk("after_rst:x_const", 64'(xr), 64'(17'h02000));

        for (int i = 0; i < 260; i++) begin
            qw.push_back(16'($urandom));
            qs.push_back(16'($urandom));
        end
        run_sum("cnt_sat", 10, 0, xr);

        for (int k = 0; k < 40; k++) begin
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3) == 0) begin
                    qw.push_back(($urandom_range(1) == 0) ? 16'h8000 : 16'h7FFF);
                    qs.push_back(($urandom_range(1) == 0) ? 16'h8000 : 16'h7FFF);
                end else begin
                    qw.push_back(16'($urandom));
                    qs.push_back(16'($urandom));
                end
            end
            run_sum($sformatf("rand%0d", k), int'($urandom_range(40)), int'($urandom_range(3)), xr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservoir_mac.md
RESERVOIR_MAC -- requirements
Module: reservoir_mac

Interface
REQ-001 The block SHALL have parameter ACC_W, default 40, setting the internal accumulator width in bits (minimum 33).
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the term-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input term is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a term.
REQ-007 The block SHALL have port in_last, input, 1 bit: the current term is the last of the dot product.
REQ-008 The block SHALL have port w, input, 16 bits: signed Q1.15 weight.
REQ-009 The block SHALL have port s, input, 16 bits: signed Q1.15 state or input sample.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port x, output, 17 bits: signed Q2.15 pre-activation sum, fed to the tanh activation stage.
REQ-013 The block SHALL have port sat, output, 1 bit: x was clipped to the 17-bit range.
REQ-014 The block SHALL have port n_terms, output, CNT_W bits: the number of terms accepted for x, saturating at 2^CNT_W-1.

Function
REQ-015 A term SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-016 The FSM SHALL have states IDLE, ACC, DRAIN and OUT.
- IDLE -> ACC on acceptance without in_last.
- IDLE or ACC -> DRAIN on acceptance with in_last.
- DRAIN -> OUT after 2 edges.
- OUT -> IDLE when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in DRAIN and OUT.
REQ-018 Stage 1: on acceptance, the product register SHALL load the full-precision signed product w*s (32-bit Q2.30).
REQ-019 Stage 2: the accumulator SHALL add the sign-extended product register one edge after acceptance.
- For the first term of a new sum, the accumulator SHALL load the product instead of adding it, so no explicit clear cycle is needed.
REQ-020 Result: on the second edge after the edge that accepts in_last, the block SHALL:
- register x = saturate(accumulator >>> 15), using an arithmetic shift that floors toward minus infinity;
- assert out_valid.
REQ-021 Saturation SHALL clip above 65535 to 17'h0FFFF and below -65536 to 17'h10000, setting sat=1; otherwise x SHALL hold the exact shifted value and sat=0.
REQ-022 While out_valid=1 and out_ready=0, x, sat, n_terms and out_valid SHALL hold stable.
REQ-023 out_valid SHALL deassert on the edge completing the output handshake, and in_ready SHALL be 1 from the following cycle.
- The minimum turnaround is 1 idle cycle between the output handshake and the next accepted term.
REQ-024 A single-term sum (in_last on the first beat) SHALL be supported with identical 2-edge latency.
REQ-025 Gaps with in_valid=0 in IDLE or ACC SHALL leave the product register and accumulator unchanged.
REQ-026 n_terms SHALL count accepted terms of the current sum, saturating rather than wrapping.
- n_terms SHALL be registered into the output together with x.
REQ-027 in_last, w and s SHALL be ignored when no acceptance occurs.
REQ-028 The accumulator SHALL not overflow internally for up to 2^(ACC_W-32) terms; beyond that, behaviour is defined only by two's-complement wrap of the accumulator.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE, in_ready=1;
- out_valid=0, x=0, sat=0, n_terms=0;
- product register and accumulator to 0.
REQ-030 Reset asserted mid-accumulation or in OUT SHALL discard the partial or pending result; the first term after release SHALL start a new sum.

Verification
REQ-031 Basic sum: 2 terms w=s=16'h4000, in_last on the 2nd -> x=17'h04000, sat=0, n_terms=2, out_valid 2 edges after the last accept.
REQ-032 Positive clip: 3 terms w=s=16'h8000 -> raw sum 98304 -> x=17'h0FFFF, sat=1, n_terms=3.
REQ-033 Negative clip: 3 terms w=16'h8000, s=16'h7FFF -> raw sum -98301 -> x=17'h10000, sat=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> x, sat, n_terms stable and in_ready=0 throughout; accept then in_ready=1 next cycle.
REQ-035 Single term w=16'h7FFF, s=16'h0001 with in_last, plus in_valid gaps within a 4-term sum -> x=17'h00000 (floor of 32767/32768) for the single term; the gapped sum equals the gap-free sum.
REQ-036 Reset mid-sum: assert rst_n=0 after 2 of 4 terms, release, send 1 term w=s=16'h4000 with in_last -> x=17'h02000, n_terms=1.
